usb_tx_serializer: RTL and testbench

//  USB TX serializer directly upstream of the NRZI/SE0 line encoder.
//  - Accepts bytes from the TX packet buffer over valid/ready; shifts them out LSB-first on serial_out.
//  - Inserts USB bit-stuff zeros and generates the per-bit shift_enable strobe.
//  - Frames each packet with EOP (eop_flag) and a return-to-J request (reset_out).

---
 rtl/usb_tx_serializer_pkg.sv | 17 +
 rtl/usb_tx_serializer_bit_timer.sv | 33 +++
 rtl/usb_tx_serializer.sv | 204 ++++++++++++++++++++
 tb/tb_usb_tx_serializer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_serializer_pkg.sv
// Shared types and constants for the USB TX serializer.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    DATA   = 3'd2,
    EOP    = 3'd3,
    IDLE_J = 3'd4
  } tx_state_t;

  // SYNC pattern sent LSB-first: 0,0,0,0,0,0,0,1
  localparam logic [7:0]  SYNC_BYTE = 8'h80;
  // Number of bit times the EOP marker occupies
  localparam int unsigned EOP_BITS  = 2;

endpackage

// File: rtl/usb_tx_serializer_bit_timer.sv
// Bit-time generator: counts 0..CLKS_PER_BIT-1 while enabled and strobes on
// the final cycle of each bit time. Held at zero when disabled or cleared.
module usb_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  input  logic clear,
  output logic strobe
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_count;

  // Free-running bit-time counter, parked at zero outside a packet
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (clear || !enable) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign strobe = enable && !clear && (r_count == LAST);

endmodule

// File: rtl/usb_tx_serializer.sv
// USB TX serializer: byte holding register, LSB-first shifter with bit
// stuffing, EOP framing and return-to-J request for the NRZI encoder.
// Build option: define USB_TX_SYNC_GEN_EN to emit the SYNC byte in hardware;
// otherwise the first byte supplied upstream must be SYNC.
module usb_tx_serializer
  import usb_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned STUFF_LEN    = 6
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       serial_out,
  output logic       shift_enable,
  output logic       eop_flag,
  output logic       reset_out,
  output logic       tx_busy,
  output logic       tx_underrun
);

  localparam int unsigned OW = $clog2(STUFF_LEN + 1);
  localparam logic [OW-1:0] STUFF_CNT = OW'(STUFF_LEN);
  localparam logic          EOP_LAST  = 1'(EOP_BITS - 1);

  tx_state_t     r_state, w_state_nxt;

  logic [7:0]    r_hold_data;
  logic          r_hold_last;
  logic          r_hold_valid;

  logic [7:0]    r_shift,    w_shift_nxt;
  logic [2:0]    r_idx,      w_idx_nxt;
  logic          r_serial,   w_serial_nxt;
  logic          r_stuff,    w_stuff_nxt;
  logic          r_last,     w_last_nxt;
  logic [OW-1:0] r_ones,     w_ones_nxt;
  logic          r_eop_cnt,  w_eop_nxt;
  logic          r_underrun, w_underrun_nxt;

  logic          w_load;
  logic          w_strobe;
  logic          w_busy;
  logic          w_clear;
  logic [2:0]    w_idx_inc;
  logic [OW-1:0] w_ones_after;

  assign w_busy    = (r_state != IDLE);
  assign w_clear   = (r_state == IDLE_J);
  assign w_idx_inc = r_idx + 3'd1;

  usb_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .n_rst  (n_rst),
    .enable (w_busy),
    .clear  (w_clear),
    .strobe (w_strobe)
  );

  // Holding register: accepts only when empty, emptied when the shifter loads
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_hold_data  <= '0;
      r_hold_last  <= 1'b0;
      r_hold_valid <= 1'b0;
    end else if (w_load) begin
      r_hold_valid <= 1'b0;
    end else if (tx_valid && !r_hold_valid) begin
      r_hold_data  <= tx_data;
      r_hold_last  <= tx_last;
      r_hold_valid <= 1'b1;
    end
  end

  // State and shift-path registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_idx      <= '0;
      r_serial   <= 1'b1;
      r_stuff    <= 1'b0;
      r_last     <= 1'b0;
      r_ones     <= '0;
      r_eop_cnt  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_idx      <= w_idx_nxt;
      r_serial   <= w_serial_nxt;
      r_stuff    <= w_stuff_nxt;
      r_last     <= w_last_nxt;
      r_ones     <= w_ones_nxt;
      r_eop_cnt  <= w_eop_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  // Next-state and next-bit selection, evaluated at each bit strobe.
  // r_serial always holds the bit currently on the line, so the bit that
  // follows is decided on the strobe and registered on the same edge; a
  // stuffed bit leaves r_idx on the data bit it follows.
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_idx_nxt      = r_idx;
    w_serial_nxt   = r_serial;
    w_stuff_nxt    = r_stuff;
    w_last_nxt     = r_last;
    w_ones_nxt     = r_ones;
    w_eop_nxt      = r_eop_cnt;
    w_underrun_nxt = 1'b0;
    w_load         = 1'b0;
    w_ones_after   = r_serial ? (r_ones + OW'(1)) : '0;

    unique case (r_state)
      IDLE: begin
        w_serial_nxt = 1'b1;
        w_ones_nxt   = '0;
        if (r_hold_valid) begin
          w_idx_nxt   = '0;
          w_stuff_nxt = 1'b0;
`ifdef USB_TX_SYNC_GEN_EN
          w_state_nxt  = SYNC;
          w_shift_nxt  = SYNC_BYTE;
          w_serial_nxt = SYNC_BYTE[0];
          w_last_nxt   = 1'b0;
`else
          w_state_nxt  = DATA;
          w_load       = 1'b1;
          w_shift_nxt  = r_hold_data;
          w_serial_nxt = r_hold_data[0];
          w_last_nxt   = r_hold_last;
`endif
        end
      end

      SYNC, DATA: begin
        if (w_strobe) begin
          w_ones_nxt  = w_ones_after;
          w_stuff_nxt = 1'b0;
          if (w_ones_after == STUFF_CNT) begin
            w_stuff_nxt  = 1'b1;
            w_serial_nxt = 1'b0;
          end else if (r_idx != 3'd7) begin
            w_idx_nxt    = w_idx_inc;
            w_serial_nxt = r_shift[w_idx_inc];
          end else if (r_last) begin
            w_state_nxt  = EOP;
            w_serial_nxt = 1'b1;
            w_eop_nxt    = 1'b0;
          end else if (r_hold_valid) begin
            w_state_nxt  = DATA;
            w_load       = 1'b1;
            w_shift_nxt  = r_hold_data;
            w_serial_nxt = r_hold_data[0];
            w_last_nxt   = r_hold_last;
            w_idx_nxt    = '0;
          end else begin
            w_underrun_nxt = 1'b1;
            w_state_nxt    = EOP;
            w_serial_nxt   = 1'b1;
            w_eop_nxt      = 1'b0;
          end
        end
      end

      EOP: begin
        w_serial_nxt = 1'b1;
        if (w_strobe) begin
          if (r_eop_cnt == EOP_LAST) begin
            w_state_nxt = IDLE_J;
          end else begin
            w_eop_nxt = r_eop_cnt + 1'b1;
          end
        end
      end

      IDLE_J: begin
        w_serial_nxt = 1'b1;
        w_state_nxt  = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign tx_ready     = !r_hold_valid;
  assign serial_out   = r_serial;
  assign shift_enable = w_strobe;
  assign eop_flag     = (r_state == EOP);
  assign reset_out    = (r_state == IDLE_J);
  assign tx_busy      = w_busy;
  assign tx_underrun  = r_underrun;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Self-checking bench for usb_tx_serializer. Expected line streams come from
// a bit-list model: SYNC (if built in) + data bits LSB-first, stuffing applied
// to the whole list, then two EOP bit times.
module tb_usb_tx_serializer;

  localparam int unsigned CPB = 8;
`ifdef USB_TX_SYNC_GEN_EN
  localparam int SYNC_N = 8;
`else
  localparam int SYNC_N = 0;
`endif
  // {serial_out, shift_enable, eop_flag, reset_out, tx_ready, tx_busy, tx_underrun}
  localparam logic [6:0] RST_VALS = 7'b1000100;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_last = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, serial_out, shift_enable, eop_flag, reset_out, tx_busy, tx_underrun;

  always #5 clk = ~clk;

  usb_tx_serializer #(
    .CLKS_PER_BIT(CPB),
    .STUFF_LEN   (6)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .tx_data      (tx_data),
    .tx_last      (tx_last),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .serial_out   (serial_out),
    .shift_enable (shift_enable),
    .eop_flag     (eop_flag),
    .reset_out    (reset_out),
    .tx_busy      (tx_busy),
    .tx_underrun  (tx_underrun)
  );

  int n_vec = 0;
  int n_fail = 0;

  logic [7:0]  pk_data[$];
  bit          pk_last;
  bit          garbage;
  int unsigned max_gap;

  bit got_bits[$], got_eop[$], exp_bits[$], exp_eop[$];
  int n_underrun, n_unstable, n_badgap, rst_len;
  bit busy_after, timeout, drv_timeout, stop_drv;
  logic [6:0]   snap;
  logic [255:0] got_vec, exp_vec;

  // Reference: flat bit list, stuffing after every sixth consecutive 1, then EOP
  task automatic build_expected();
    bit stream[$];
    int ones;
    logic [7:0] b;
    exp_bits.delete();
    exp_eop.delete();
`ifdef USB_TX_SYNC_GEN_EN
    b = 8'h80;
    for (int k = 0; k < 8; k++) stream.push_back(b[k]);
`endif
    foreach (pk_data[i]) begin
      b = pk_data[i];
      for (int k = 0; k < 8; k++) stream.push_back(b[k]);
    end
    ones = 0;
    foreach (stream[i]) begin
      exp_bits.push_back(stream[i]);
      exp_eop.push_back(1'b0);
      ones = stream[i] ? ones + 1 : 0;
      if (ones == 6) begin
        exp_bits.push_back(1'b0);
        exp_eop.push_back(1'b0);
        ones = 0;
      end
    end
    for (int k = 0; k < 2; k++) begin
      exp_bits.push_back(1'b1);
      exp_eop.push_back(1'b1);
    end
  endtask

  // Offers the packet bytes; optionally drives junk with tx_valid while full
  task automatic drive();
    int waited;
    bit accepted;
    for (int i = 0; i < pk_data.size(); i++) begin
      int unsigned gap = $urandom_range(0, max_gap);
      for (int g = 0; g < int'(gap) && !stop_drv; g++) begin
        @(negedge clk);
        tx_valid = 1'b0;
      end
      accepted = 1'b0;
      waited = 0;
      while (!accepted && !stop_drv && waited < 400) begin
        @(negedge clk);
        if (tx_ready) begin
          tx_data  = pk_data[i];
          tx_last  = pk_last && (i == pk_data.size() - 1);
          tx_valid = 1'b1;
          @(posedge clk);
          accepted = 1'b1;
        end else if (garbage) begin
          tx_data  = 8'($urandom);
          tx_last  = 1'($urandom_range(0, 1));
          tx_valid = 1'b1;
        end else begin
          tx_valid = 1'b0;
        end
        waited++;
      end
      if (!accepted && !stop_drv) drv_timeout = 1'b1;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  // Records each strobed bit and frame events; abort_at>0 pulls n_rst at that strobe
  task automatic collect(input int abort_at);
    int cyc, since;
    bit done, prev;
    got_bits.delete();
    got_eop.delete();
    n_underrun = 0; n_unstable = 0; n_badgap = 0; rst_len = 0;
    busy_after = 1'b1; timeout = 1'b0; done = 1'b0;
    cyc = 0; since = 0; prev = 1'b1;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (tx_underrun) n_underrun++;
      if (tx_busy && !reset_out) begin
        if (since > 0 && serial_out !== prev) n_unstable++;
        since++;
        prev = serial_out;
        if (shift_enable) begin
          got_bits.push_back(serial_out);
          got_eop.push_back(eop_flag);
          if (since != int'(CPB)) n_badgap++;
          since = 0;
          if (abort_at > 0 && got_bits.size() == abort_at) begin
            n_rst = 1'b0;
            #1;
            snap = {serial_out, shift_enable, eop_flag, reset_out, tx_ready, tx_busy, tx_underrun};
            done = 1'b1;
          end
        end
      end
      if (!done && reset_out) begin
        rst_len = 1;
        @(negedge clk);
        if (reset_out) rst_len++;
        busy_after = tx_busy;
        done = 1'b1;
      end
    end
    if (!done) timeout = 1'b1;
    stop_drv = 1'b1;
  endtask

  task automatic run(input int abort_at);
    stop_drv = 1'b0;
    drv_timeout = 1'b0;
    build_expected();
    fork
      drive();
      collect(abort_at);
    join
    got_vec = '0;
    exp_vec = '0;
    for (int i = 0; i < got_bits.size() && i < 128; i++) got_vec[2*i +: 2] = {got_eop[i], got_bits[i]};
    for (int i = 0; i < exp_bits.size() && i < 128; i++) exp_vec[2*i +: 2] = {exp_eop[i], exp_bits[i]};
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    tx_valid = 1'b1;
    tx_data = 8'h5A;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({serial_out, shift_enable, eop_flag, reset_out, tx_ready, tx_busy, tx_underrun} !== RST_VALS) begin
      n_fail++;
      $display("FAIL reset_values got=%b want=%b",
               {serial_out, shift_enable, eop_flag, reset_out, tx_ready, tx_busy, tx_underrun}, RST_VALS);
    end
    tx_valid = 1'b0;
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({tx_ready, tx_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL idle_after_reset got=%b want=10", {tx_ready, tx_busy});
    end
  endtask

  task automatic test_sync_a5();
    pk_data = '{8'hA5}; pk_last = 1'b1; garbage = 1'b0; max_gap = 0;
    run(0);
    n_vec++;
    if (got_vec !== exp_vec) begin n_fail++; $display("FAIL a5_stream got=%h want=%h", got_vec, exp_vec); end
    n_vec++;
    if (got_bits.size() != SYNC_N + 10) begin n_fail++; $display("FAIL a5_strobes got=%0d want=%0d", got_bits.size(), SYNC_N + 10); end
    n_vec++;
    if (rst_len != 1 || busy_after !== 1'b0) begin n_fail++; $display("FAIL a5_frame rst_len=%0d busy_after=%b want 1,0", rst_len, busy_after); end
    n_vec++;
    if (n_unstable + n_badgap != 0 || timeout || drv_timeout) begin
      n_fail++; $display("FAIL a5_timing unstable=%0d badgap=%0d timeout=%b/%b want 0", n_unstable, n_badgap, timeout, drv_timeout);
    end
  endtask

  task automatic test_stuff_ff();
    pk_data = '{8'hFF}; pk_last = 1'b1; garbage = 1'b0; max_gap = 0;
    run(0);
    n_vec++;
    if (got_vec !== exp_vec) begin n_fail++; $display("FAIL ff_stream got=%h want=%h", got_vec, exp_vec); end
    n_vec++;
    if (got_bits.size() != SYNC_N + 11) begin n_fail++; $display("FAIL ff_strobes got=%0d want=%0d", got_bits.size(), SYNC_N + 11); end
    n_vec++;
    if (n_underrun != 0 || timeout) begin n_fail++; $display("FAIL ff_flags underrun=%0d timeout=%b want 0", n_underrun, timeout); end
  endtask

  task automatic test_back_to_back();
    pk_data = '{8'h3F, 8'h03}; pk_last = 1'b1; garbage = 1'b0; max_gap = 0;
    run(0);
    n_vec++;
    if (got_vec !== exp_vec) begin n_fail++; $display("FAIL b2b_stream got=%h want=%h", got_vec, exp_vec); end
    n_vec++;
    if (n_badgap != 0 || n_unstable != 0 || timeout || drv_timeout) begin
      n_fail++; $display("FAIL b2b_timing badgap=%0d unstable=%0d timeout=%b/%b want 0", n_badgap, n_unstable, timeout, drv_timeout);
    end
  endtask

  task automatic test_underrun();
    pk_data = '{8'h12}; pk_last = 1'b0; garbage = 1'b0; max_gap = 0;
    run(0);
    n_vec++;
    if (n_underrun != 1) begin n_fail++; $display("FAIL underrun_pulses got=%0d want=1", n_underrun); end
    n_vec++;
    if (got_vec !== exp_vec) begin n_fail++; $display("FAIL underrun_stream got=%h want=%h", got_vec, exp_vec); end
    n_vec++;
    if (rst_len != 1 || busy_after !== 1'b0) begin n_fail++; $display("FAIL underrun_frame rst_len=%0d busy_after=%b want 1,0", rst_len, busy_after); end
  endtask

  task automatic test_abort();
    pk_data = '{8'hFF, 8'hFF}; pk_last = 1'b0; garbage = 1'b0; max_gap = 0;
    run(SYNC_N + 5);
    n_vec++;
    if (snap !== RST_VALS) begin n_fail++; $display("FAIL abort_outputs got=%b want=%b", snap, RST_VALS); end
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    pk_data = '{8'h00}; pk_last = 1'b1;
    run(0);
    n_vec++;
    if (got_vec !== exp_vec) begin n_fail++; $display("FAIL abort_next_stream got=%h want=%h", got_vec, exp_vec); end
    n_vec++;
    if (n_underrun != 0 || timeout) begin n_fail++; $display("FAIL abort_next_flags underrun=%0d timeout=%b want 0", n_underrun, timeout); end
  endtask

  task automatic test_hold_full();
    pk_data = '{8'($urandom), 8'($urandom), 8'($urandom)}; pk_last = 1'b1; garbage = 1'b1; max_gap = 0;
    run(0);
    n_vec++;
    if (got_vec !== exp_vec) begin n_fail++; $display("FAIL hold_full_stream got=%h want=%h", got_vec, exp_vec); end
    n_vec++;
    if (timeout || drv_timeout) begin n_fail++; $display("FAIL hold_full_timeout got=%b/%b want 0/0", timeout, drv_timeout); end
  endtask

  task automatic test_random();
    for (int p = 0; p < 10; p++) begin
      int nb = $urandom_range(1, 4);
      pk_data.delete();
      for (int i = 0; i < nb; i++) begin
        case ($urandom_range(0, 3))
          0:       pk_data.push_back(8'hFF);
          1:       pk_data.push_back(8'h7F);
          2:       pk_data.push_back(8'hFC);
          default: pk_data.push_back(8'($urandom));
        endcase
      end
      pk_last = 1'b1;
      garbage = 1'($urandom_range(0, 1));
      max_gap = 20;
      run(0);
      n_vec++;
      if (got_vec !== exp_vec) begin n_fail++; $display("FAIL random_stream pkt=%0d got=%h want=%h", p, got_vec, exp_vec); end
      n_vec++;
      if (n_underrun != 0 || n_badgap != 0 || n_unstable != 0 || rst_len != 1 || timeout || drv_timeout) begin
        n_fail++;
        $display("FAIL random_frame pkt=%0d underrun=%0d badgap=%0d unstable=%0d rst_len=%0d timeout=%b/%b want 0,0,0,1,0/0",
                 p, n_underrun, n_badgap, n_unstable, rst_len, timeout, drv_timeout);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sync_a5();
    test_stuff_ff();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_hold_full();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
